// File: rtl/cordic_log_pkg.sv
// Shared types and constants for the hyperbolic CORDIC log controller.
// Repeat indices 4 and 13 guarantee hyperbolic-mode convergence.
package cordic_log_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_ITER_DEF = 16;
  localparam int REP_A      = 4;
  localparam int REP_B      = 13;

endpackage

// File: rtl/cordic_iter_seq.sv
// Shift-index sequencer: counts 1..N_ITER, issuing REP_A and REP_B twice.
// last marks the final issue of N_ITER (after its repeat, if it has one).
module cordic_iter_seq
  import cordic_log_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int SW     = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  output logic [SW-1:0] shift,
  output logic          last
);

  logic rep;
  logic rep_pt;

  assign rep_pt = (shift == SW'(REP_A)) ||
                  (shift == SW'(REP_B));
  assign last   = (shift == SW'(N_ITER)) &&
                  !(rep_pt && !rep);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift <= '0;
      rep   <= 1'b0;
    end else if (start) begin
      shift <= SW'(1);
      rep   <= 1'b0;
    end else if (step) begin
      if (last) begin
        shift <= '0;
        rep   <= 1'b0;
      end else if (rep_pt && !rep) begin
        rep   <= 1'b1;
      end else begin
        shift <= shift + SW'(1);
        rep   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cordic_log_ctrl.sv
// Control FSM for an iterative hyperbolic CORDIC natural-log unit.
// Define CORDIC_LOG_ABORT_EN to add the abort input.
module cordic_log_ctrl
  import cordic_log_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int SW     = 5
) (
  input  logic          clk,
  input  logic          reset,
`ifdef CORDIC_LOG_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  output logic          dp_load,
  output logic          dp_en,
  output logic [SW-1:0] dp_shift,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  state_e        state;
  state_e        nxt;
  logic          last;
  logic [SW-1:0] shift;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)  nxt = ITER;
      ITER:    if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
`ifdef CORDIC_LOG_ABORT_EN
    if (abort && state != IDLE) nxt = IDLE;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // dp_load is gated so reset wins over a pending operand.
  assign in_ready  = (state == IDLE);
  assign dp_load   = in_ready && in_valid && !reset;
  assign dp_en     = (state == ITER);
  assign dp_shift  = dp_en ? shift : '0;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  cordic_iter_seq #(
    .N_ITER (N_ITER),
    .SW     (SW)
  ) u_seq (
    .clk   (clk),
    .reset (reset),
    .start (dp_load),
    .step  (dp_en),
    .shift (shift),
    .last  (last)
  );

endmodule

// File: tb/tb_cordic_log_ctrl.sv
// Directed bench for cordic_log_ctrl (default and N_ITER=13 builds).
// Abort vectors run when CORDIC_LOG_ABORT_EN is defined.
module tb_cordic_log_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, dp_load, dp_en, out_valid, busy;
  logic [4:0] dp_shift;
`ifdef CORDIC_LOG_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic       iv13 = 1'b0;
  logic       or13 = 1'b0;
  logic       ir13, ld13, en13, ov13, busy13;
  logic [4:0] sh13;

  int errors = 0;
  int checks = 0;
  int ov_cnt;

  int seq16[18] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9,
                    10, 11, 12, 13, 13, 14, 15, 16};
  int seq13[15] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9,
                    10, 11, 12, 13, 13};

  always #5 clk = ~clk;

  cordic_log_ctrl dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CORDIC_LOG_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dp_load   (dp_load),
    .dp_en     (dp_en),
    .dp_shift  (dp_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  cordic_log_ctrl #(.N_ITER(13), .SW(5)) dut13 (
    .clk       (clk),
    .reset     (reset),
`ifdef CORDIC_LOG_ABORT_EN
    .abort     (1'b0),
`endif
    .in_valid  (iv13),
    .in_ready  (ir13),
    .dp_load   (ld13),
    .dp_en     (en13),
    .dp_shift  (sh13),
    .out_valid (ov13),
    .out_ready (or13),
    .busy      (busy13)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  initial begin
    in_valid = 1'b1;
    #1;
    chk("rst_load", 32'(dp_load), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(dp_en), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_shift", 32'(dp_shift), 0);

    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(in_ready), 1);

    // run 1: full sequence, stray in_valid at ITER cycle 7
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("acc_load", 32'(dp_load), 1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      in_valid = (k == 6);
      #1;
      chk($sformatf("r1_shift%0d", k),
          32'(dp_shift), 32'(seq16[k]));
      chk("r1_en", 32'(dp_en), 1);
      chk("r1_ov", 32'(out_valid), 0);
      if (k == 6) begin
        chk("stray_load", 32'(dp_load), 0);
        chk("stray_ready", 32'(in_ready), 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("done_ov", 32'(out_valid), 1);
    chk("done_en", 32'(dp_en), 0);
    chk("done_shift", 32'(dp_shift), 0);
    chk("done_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_ov", 32'(out_valid), 1);
      chk("hold_en", 32'(dp_en), 0);
    end

    // handoff: no accept while DONE drains
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("hand_ready", 32'(in_ready), 0);
    chk("hand_load", 32'(dp_load), 0);
    chk("hand_ov", 32'(out_valid), 1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("back_ready", 32'(in_ready), 1);
    chk("back_ov", 32'(out_valid), 0);
    chk("back_busy", 32'(busy), 0);
    chk("back_load", 32'(dp_load), 1);

    // run 2: reset at ITER cycle 10
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("r2_shift%0d", k),
          32'(dp_shift), 32'(seq16[k]));
    end
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_shift", 32'(dp_shift), 0);
    chk("mid_rst_en", 32'(dp_en), 0);
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) ov_cnt++;
    end
    chk("no_ov_after_rst", 32'(ov_cnt), 0);

    // N_ITER=13, out_ready held high throughout
    @(negedge clk);
    iv13 = 1'b1;
    or13 = 1'b1;
    #1;
    chk("n13_load", 32'(ld13), 1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      iv13 = 1'b0;
      #1;
      chk($sformatf("n13_shift%0d", k),
          32'(sh13), 32'(seq13[k]));
      chk("n13_ov", 32'(ov13), 0);
    end
    @(negedge clk);
    #1;
    chk("n13_done_ov", 32'(ov13), 1);
    chk("n13_done_en", 32'(en13), 0);
    @(negedge clk);
    or13 = 1'b0;
    #1;
    chk("n13_idle_busy", 32'(busy13), 0);
    chk("n13_idle_ready", 32'(ir13), 1);

`ifdef CORDIC_LOG_ABORT_EN
    // abort in IDLE is ignored; abort at ITER cycle 5
    @(negedge clk);
    abort = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("ab_idle_load", 32'(dp_load), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      abort = (k == 4);
      #1;
      chk($sformatf("ab_shift%0d", k),
          32'(dp_shift), 32'(seq16[k]));
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ov", 32'(out_valid), 0);
    chk("ab_en", 32'(dp_en), 0);
    chk("ab_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    #1;
    chk("ab_reacc", 32'(dp_load), 1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("ab2_shift%0d", k),
          32'(dp_shift), 32'(seq16[k]));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("ab2_ov", 32'(out_valid), 1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("ab2_idle", 32'(busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_log_ctrl.md
CORDIC_LOG_CTRL -- requirements
Module: cordic_log_ctrl

Interface
REQ-001 SHALL have parameter N_ITER, default 16, giving the last hyperbolic shift index (legal range 13..31).
REQ-002 SHALL have parameter SW, default 5, giving the shift-index width; N_ITER SHALL fit in SW bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the front-end operand (x, y, exponent) is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts an operand this cycle.
REQ-007 SHALL have port dp_load, output, 1 bit: the datapath loads x, y and exponent, and clears z.
REQ-008 SHALL have port dp_en, output, 1 bit: the datapath performs one micro-rotation this cycle.
REQ-009 SHALL have port dp_shift, output, SW bits: the current shift index i, which is also the atanh table address.
REQ-010 SHALL have port out_valid, output, 1 bit: the datapath result (z, exponent) is final.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ITER and DONE.
REQ-014 IDLE: in_ready=1; when in_valid=1, dp_load SHALL be 1 in the same cycle (combinational) and the next state SHALL be ITER with dp_shift=1.
REQ-015 ITER: in_ready=0 and dp_en=1 in every cycle; dp_shift SHALL follow 1,2,3,4,4,5,...,13,13,14,...,N_ITER.
REQ-016 Index 4 and index 13 SHALL each be issued twice in consecutive cycles (hyperbolic convergence repeats); every other index is issued once.
REQ-017 ITER SHALL go to DONE after the cycle that issues N_ITER when no repeat of N_ITER is pending; with N_ITER=13, 13 is issued twice before DONE.
REQ-018 Iteration cycle count SHALL be N_ITER+2 (18 at the default); the accept cycle is T, ITER occupies T+1..T+N_ITER+2, and out_valid rises at T+N_ITER+3.
REQ-019 DONE: out_valid=1 and dp_en=0; out_valid SHALL hold until out_ready=1; on out_ready=1 the next state SHALL be IDLE.
REQ-020 No operand SHALL be accepted in the DONE-to-IDLE handoff cycle; back-to-back throughput is one operand per N_ITER+4 cycles minimum.
REQ-021 in_valid while not in IDLE SHALL be ignored, and the upstream operand SHALL NOT be consumed.
REQ-022 dp_shift SHALL read 0 in IDLE and DONE.
REQ-023 out_ready while not in DONE SHALL have no effect.

Reset
REQ-024 reset SHALL force state IDLE, dp_shift=0, the repeat flag to 0, and dp_load=dp_en=out_valid=busy=0, with in_ready=1, asynchronously.
REQ-025 reset during ITER or DONE SHALL abandon the operation; no out_valid SHALL follow for that operand.

Configuration
REQ-026 SHALL use the macro CORDIC_LOG_ABORT_EN to compile the abort feature in or out.
REQ-027 With CORDIC_LOG_ABORT_EN defined: input port abort (1 bit); abort=1 in ITER or DONE SHALL return the FSM to IDLE on the next edge, with out_valid=0 and dp_en=0 from that edge on.
REQ-028 With CORDIC_LOG_ABORT_EN defined: abort=1 in IDLE SHALL be ignored, and abort SHALL take priority over out_ready in DONE.
REQ-029 Without CORDIC_LOG_ABORT_EN: the abort port is absent and the FSM has only the transitions above.

Structure
REQ-030 Package cordic_log_pkg SHALL hold the state enum, the default N_ITER, and the repeat-index constants REP_A=4 and REP_B=13.
REQ-031 Sub-module cordic_iter_seq SHALL hold the shift counter and repeat flag: inputs start and step; outputs shift and last.
REQ-032 The FSM SHALL remain in cordic_log_ctrl.

Verification
REQ-033 Reset release, then in_valid=1 at T -> dp_load=1 at T; dp_shift sequence 1,2,3,4,4,5..13,13,14,15,16 over T+1..T+18; out_valid=1 at T+19.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1 and dp_en stays 0; out_ready=1 -> IDLE next cycle with in_ready=1.
REQ-035 in_valid pulsed at ITER cycle 7 -> no dp_load, and the dp_shift sequence is unchanged.
REQ-036 reset asserted at ITER cycle 10 -> all outputs take reset values immediately; no out_valid afterwards.
REQ-037 N_ITER=13 -> sequence 1..4,4,5..13,13 (15 cycles); out_valid at T+16.
REQ-038 CORDIC_LOG_ABORT_EN defined, abort=1 at ITER cycle 5 -> IDLE next edge, no out_valid; the next in_valid is accepted normally.
